// File: rtl/comparator_3_bits_tracker.sv
// Window statistics collector for a 3-bit magnitude comparator stream.
// Accumulates gt/eq/lt/illegal counts and max A over WINDOW samples, then holds the summary until it is taken.
module comparator_3_bits_tracker #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_A,
  input  logic [2:0]       in_C,
  output logic             out_accept,
  input  logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic [2:0]       out_max_A
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;

  // Handshake outputs are pure state decodes, so neither in_valid nor in_ready reaches an output combinationally.
  assign out_accept = (state == ACCUM);
  assign out_valid  = (state == HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state       <= ACCUM;
      sample_cnt  <= '0;
      out_gt_cnt  <= '0;
      out_eq_cnt  <= '0;
      out_lt_cnt  <= '0;
      out_err_cnt <= '0;
      out_max_A   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            case (in_C)
              3'b100:  out_gt_cnt  <= out_gt_cnt + ONE;
              3'b010:  out_eq_cnt  <= out_eq_cnt + ONE;
              3'b001:  out_lt_cnt  <= out_lt_cnt + ONE;
              default: out_err_cnt <= out_err_cnt + ONE;
            endcase
            if (in_A > out_max_A) out_max_A <= in_A;
            if (sample_cnt == LAST_IDX) begin
              sample_cnt <= '0;
              state      <= HOLD;
            end else begin
              sample_cnt <= sample_cnt + ONE;
            end
          end
        end
        HOLD: begin
          // Summary stays frozen until downstream takes it; the clear starts the next window from zero.
          if (in_ready) begin
            out_gt_cnt  <= '0;
            out_eq_cnt  <= '0;
            out_lt_cnt  <= '0;
            out_err_cnt <= '0;
            out_max_A   <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/comparator_3_bits_tracker.md
# comparator_3_bits_tracker

Downstream consumer of the 3-bit magnitude comparator. It accepts a stream of comparison results (`in_C`) with the matching A operand under a valid/accept handshake. Over a window of `WINDOW` accepted samples it accumulates greater/equal/less counts, the maximum A value and an illegal-code count, then presents the summary under a valid/ready handshake. It turns the comparator's per-cycle verdicts into window statistics for the next stage.

## Interface
- `WINDOW`, 8: number of accepted samples per summary; legal range 1..15.
- `CNT_W`, 4: width of every count output; must satisfy 2^CNT_W > WINDOW.

- `in_clk`  input  1: sole clock, rising edge.
- `in_rst_n`  input  1: reset, synchronous and active-low.
- `in_valid`  input  1: upstream presents a sample this cycle.
- `in_A`  input  3: A operand that produced `in_C`.
- `in_C`  input  3: comparator verdict, one-hot: [2] A>B, [1] A==B, [0] A<B.
- `out_accept`  output  1: block takes the sample this cycle.
- `in_ready`  input  1: downstream takes the summary this cycle.
- `out_valid`  output  1: summary is stable and valid.
- `out_gt_cnt`  output  CNT_W: samples with `in_C`=100.
- `out_eq_cnt`  output  CNT_W: samples with `in_C`=010.
- `out_lt_cnt`  output  CNT_W: samples with `in_C`=001.
- `out_err_cnt`  output  CNT_W: samples whose `in_C` is not one-hot.
- `out_max_A`  output  3: largest `in_A` accepted in the window.

## Operation
- The FSM has two states, ACCUM and HOLD. Reset enters ACCUM.
- ACCUM:
  - `out_accept`=1 and `out_valid`=0.
  - An accept happens when `in_valid`=1 in a cycle.
  - On accept, the sample counter increments and exactly one of gt/eq/lt/err increments. The classification is 100→gt, 010→eq, 001→lt, and any other code (000, 011, 101, 110, 111)→err.
  - On accept, `out_max_A` ← max(`out_max_A`, `in_A`). The comparison is unsigned.
  - When the accepted sample is the WINDOW-th, the counters update with it and the state goes to HOLD on the same edge. The sample counter clears.
- HOLD:
  - `out_accept`=0 and `out_valid`=1.
  - All summary outputs are frozen. Upstream samples are not taken; `in_valid` is ignored.
  - When `in_ready`=1, the transfer completes. All count outputs and `out_max_A` clear to 0 and the state goes to ACCUM.
- The count outputs are the live accumulators. They are meaningful to downstream only while `out_valid`=1.
- Invariant in HOLD: gt+eq+lt+err = WINDOW. Counts never wrap, given the `CNT_W` rule.
- `in_ready` is ignored in ACCUM. `in_valid` is ignored in HOLD.
- Synchronous reset (`in_rst_n`=0 at an edge) returns the block to ACCUM regardless of state, including mid-window and mid-HOLD. The partial window is discarded.

## Timing
- Reset values: `out_accept`=1, `out_valid`=0, all counts 0, `out_max_A`=0. `out_accept` reads 1 during reset because the state is ACCUM.
- Outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`in_ready` to any output.
- Latency: `out_valid` rises on the edge that accepts the WINDOW-th sample, so it is visible the cycle after that sample is presented.
- HOLD lasts at least 1 cycle. If `in_ready`=1 on the first HOLD cycle, `out_accept` returns to 1 the next cycle.
- Minimum period per window is WINDOW+1 cycles.
- Backpressure: `out_valid` and all summary values stay stable until `in_ready`=1. No summary is dropped or overwritten.
- `in_valid` gaps in ACCUM only delay the window. Counts are unaffected.
- WINDOW=1: every accepted sample produces a summary, then at least 1 HOLD cycle.

## Test plan
- Reset: hold `in_rst_n`=0 for 2 cycles with `in_valid`=1 and `in_C`=100 → all counts 0, `out_max_A`=0, `out_valid`=0, `out_accept`=1.
- Full sweep, WINDOW=8:
  - Stimulus: `in_A`=a and `in_C` driven from a reference A-vs-B compare for each of the 64 (a,b) pairs, with `in_valid`=1 and `in_ready`=1.
  - Response: 8 summaries. Summary for a=k has gt=k, eq=1, lt=7−k, err=0, `out_max_A`=k. Each `out_valid` pulse is exactly 1 cycle wide.
- Illegal codes: a window of 000,011,100,100,010,111,001,001 with `in_A`=3,0,5,2,1,7,4,6 → gt=2, eq=1, lt=2, err=3, max=7.
- Backpressure: complete a window with `in_ready`=0 for 5 cycles while `in_valid`=1 with changing data → outputs frozen, `out_accept`=0 and no sample counted. After `in_ready`=1, the next window's counts start from 0.
- Gapped input: 8 samples of 010 with `in_valid` toggling 1,0 → `out_valid` rises after the 8th accepted sample (cycle 15 after the first), eq=8.
- Reset mid-operation: 5 samples accepted then `in_rst_n`=0 for 1 cycle, then 8 samples of 001 → summary lt=8, with no residue from the aborted window. Repeat with reset asserted during HOLD → `out_valid` drops the cycle after reset.
